matrix_rd_arbiter: RTL and testbench

- Shares one AXI-MM read port between two matrix fetch engines (requester 0, requester 1).
- Arbitrates AR requests round-robin and tags each with a 1-bit ARID equal to the requester index.
- Routes R beats back by RID and enforces a per-requester outstanding-burst limit.
- Sits between the matrix_multiply0/1 read masters and the DMA/memory read channel; also exports debug counters to status_reg.

---
 rtl/matrix_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_matrix_rd_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_rd_arbiter.sv
// Two-requester AXI read-channel arbiter: round-robin AR grant with ARID tagging,
// RID-routed zero-latency R path and per-requester outstanding-burst limiting.
module matrix_rd_arbiter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int LEN_W           = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic              s0_arvalid,
  input  logic              s1_arvalid,
  output logic              s0_arready,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s0_rlast,
  output logic              s1_rlast,
  output logic              s0_rvalid,
  output logic              s1_rvalid,
  input  logic              s0_rready,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic              m_arid,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rid,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [31:0]       ar_cnt0,
  output logic [31:0]       ar_cnt1,
  output logic              busy,
  output logic              err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              pref_q, pref_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              id_q, id_d;
  logic [OW-1:0]     os_q [2];
  logic [OW-1:0]     os_d [2];
  logic [31:0]       cnt_q [2];
  logic [31:0]       cnt_d [2];
  logic              err_q, err_d;

  logic [1:0] arvalid_v;
  logic [1:0] elig;
  logic [1:0] inc;
  logic [1:0] dec;
  logic       grant;
  logic       gsel;
  logic       last_hs;

  assign arvalid_v = {s1_arvalid, s0_arvalid};

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = arvalid_v[i] && (os_q[i] < MAX_OS);
    end
    grant = (state_q == IDLE) && en && (elig != 2'b00);
    // With both eligible, pref_q names the requester not granted last.
    gsel  = (elig == 2'b11) ? pref_q : elig[1];
  end

  assign s0_arready = grant && !gsel;
  assign s1_arready = grant && gsel;

  assign s0_rvalid = m_rvalid && !m_rid;
  assign s1_rvalid = m_rvalid && m_rid;
  assign m_rready  = m_rid ? s1_rready : s0_rready;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign last_hs   = m_rvalid && m_rready && m_rlast;

  always_comb begin
    state_d = state_q;
    pref_d  = pref_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    err_d   = err_q;
    for (int unsigned i = 0; i < 2; i++) begin
      os_d[i]  = os_q[i];
      cnt_d[i] = cnt_q[i];
      inc[i]   = grant && (gsel == 1'(i));
      dec[i]   = last_hs && (m_rid == 1'(i));
    end

    if (grant) begin
      state_d = HOLD;
      pref_d  = !gsel;
      addr_d  = gsel ? s1_araddr : s0_araddr;
      len_d   = gsel ? s1_arlen : s0_arlen;
      id_d    = gsel;
    end else if ((state_q == HOLD) && m_arready) begin
      state_d = IDLE;
    end

    for (int unsigned i = 0; i < 2; i++) begin
      if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
      // A last beat against an empty counter is flagged, never underflowed.
      if (dec[i] && (os_q[i] == '0)) begin
        err_d = 1'b1;
      end
      if (inc[i] && !dec[i]) begin
        os_d[i] = os_q[i] + OW'(1);
      end else if (dec[i] && !inc[i] && (os_q[i] != '0)) begin
        os_d[i] = os_q[i] - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pref_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= 1'b0;
      os_q    <= '{default: '0};
      cnt_q   <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pref_q  <= pref_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      os_q    <= os_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arid    = id_q;
  assign m_arvalid = (state_q == HOLD);
  assign ar_cnt0   = cnt_q[0];
  assign ar_cnt1   = cnt_q[1];
  assign err       = err_q;
  assign busy      = (state_q == HOLD) || (os_q[0] != '0) || (os_q[1] != '0);

endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// Directed bench for matrix_rd_arbiter with a cycle-level reference model checked on every negedge.
module tb_matrix_rd_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rstn, en;
  logic [AW-1:0] s0_araddr, s1_araddr;
  logic [LW-1:0] s0_arlen, s1_arlen;
  logic          s0_arvalid, s1_arvalid;
  logic          s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic          s0_rlast, s1_rlast;
  logic          s0_rvalid, s1_rvalid;
  logic          s0_rready, s1_rready;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic          m_arid, m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic          m_rlast, m_rid, m_rvalid, m_rready;
  logic [31:0]   ar_cnt0, ar_cnt1;
  logic          busy, err;

  matrix_rd_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .s0_araddr(s0_araddr), .s1_araddr(s1_araddr),
    .s0_arlen(s0_arlen), .s1_arlen(s1_arlen),
    .s0_arvalid(s0_arvalid), .s1_arvalid(s1_arvalid),
    .s0_arready(s0_arready), .s1_arready(s1_arready),
    .s0_rdata(s0_rdata), .s1_rdata(s1_rdata),
    .s0_rlast(s0_rlast), .s1_rlast(s1_rlast),
    .s0_rvalid(s0_rvalid), .s1_rvalid(s1_rvalid),
    .s0_rready(s0_rready), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .ar_cnt0(ar_cnt0), .ar_cnt1(ar_cnt1), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending-AR flag plus integer bookkeeping.
  bit          mvalid = 1'b0;
  bit          m_hold, m_pref, m_id, m_err;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  int          m_out [2];
  longint      m_cnt [2];

  always @(negedge clk) begin : model
    bit e0, e1, gr, g, rr;
    bit inc [2];
    bit dec [2];
    e0 = s0_arvalid && (m_out[0] < MAXO);
    e1 = s1_arvalid && (m_out[1] < MAXO);
    gr = !m_hold && en && (e0 || e1);
    g  = (e0 && e1) ? m_pref : e1;
    rr = m_rid ? s1_rready : s0_rready;
    if (mvalid) begin
      chk("s0_arready", s0_arready, gr && !g);
      chk("s1_arready", s1_arready, gr && g);
      chk("m_arvalid", m_arvalid, m_hold);
      chk("m_araddr", m_araddr, m_addr);
      chk("m_arlen", m_arlen, m_len);
      chk("m_arid", m_arid, m_id);
      chk("s0_rvalid", s0_rvalid, m_rvalid && !m_rid);
      chk("s1_rvalid", s1_rvalid, m_rvalid && m_rid);
      chk("m_rready", m_rready, rr);
      chk("s0_rdata", s0_rdata, m_rdata);
      chk("s1_rdata", s1_rdata, m_rdata);
      chk("s0_rlast", s0_rlast, m_rlast);
      chk("s1_rlast", s1_rlast, m_rlast);
      chk("ar_cnt0", ar_cnt0, m_cnt[0] % (64'd1 << 32));
      chk("ar_cnt1", ar_cnt1, m_cnt[1] % (64'd1 << 32));
      chk("busy", busy, m_hold || m_out[0] != 0 || m_out[1] != 0);
      chk("err", err, m_err);
    end
    if (!rstn) begin
      m_hold = 0; m_pref = 0; m_id = 0; m_err = 0;
      m_addr = '0; m_len = '0;
      m_out[0] = 0; m_out[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        inc[i] = gr && (g == i);
        dec[i] = m_rvalid && rr && m_rlast && (m_rid == i);
      end
      if (gr) begin
        m_hold = 1; m_pref = !g; m_id = g;
        m_addr = g ? s1_araddr : s0_araddr;
        m_len  = g ? s1_arlen : s0_arlen;
        m_cnt[g] = m_cnt[g] + 1;
      end else if (m_hold && m_arready) begin
        m_hold = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (dec[i] && m_out[i] == 0) m_err = 1;
        if (inc[i] && !dec[i]) m_out[i] = m_out[i] + 1;
        else if (dec[i] && !inc[i] && m_out[i] > 0) m_out[i] = m_out[i] - 1;
      end
    end
  end

  initial begin
    int n;
    bit g;
    rstn = 0; en = 0;
    s0_araddr = '0; s1_araddr = '0; s0_arlen = '0; s1_arlen = '0;
    s0_arvalid = 0; s1_arvalid = 0; s0_rready = 0; s1_rready = 0;
    m_arready = 0; m_rdata = '0; m_rlast = 0; m_rid = 0; m_rvalid = 0;
    tick(); tick();
    rstn = 1; en = 1; #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt0", ar_cnt0, 0);

    // Single request, 8-beat burst
    s0_araddr = 32'h1000; s0_arlen = 8'd7; s0_arvalid = 1; m_arready = 1; #1;
    chk("t1_s0_grant", s0_arready, 1);
    chk("t1_s1_nogrant", s1_arready, 0);
    tick(); s0_arvalid = 0; #1;
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_arid", m_arid, 0);
    chk("t1_araddr", m_araddr, 32'h1000);
    chk("t1_arlen", m_arlen, 7);
    tick();
    s0_rready = 1; s1_rready = 1;
    for (int b = 0; b < 8; b++) begin
      m_rvalid = 1; m_rid = 0; m_rlast = (b == 7); m_rdata = 32'hA000 + b; #1;
      chk("t1_s0_rvalid", s0_rvalid, 1);
      chk("t1_s1_rvalid", s1_rvalid, 0);
      chk("t1_rdata", s0_rdata, 32'hA000 + b);
      tick();
    end
    m_rvalid = 0; m_rlast = 0; #1;
    chk("t1_busy_low", busy, 0);
    chk("t1_cnt0", ar_cnt0, 1);

    // Round-robin alternation with single-beat returns
    rstn = 0; tick(); rstn = 1;
    s0_arvalid = 1; s1_arvalid = 1; s1_araddr = 32'h5000; s1_arlen = 8'd3;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 0; m_rlast = 0; #1;
      g = s1_arready;
      chk("t2_one_grant", {1'b0, s0_arready} + {1'b0, s1_arready}, 1);
      chk("t2_rr_order", g, i % 2);
      tick();
      m_rvalid = 1; m_rid = g; m_rlast = 1;
      tick();
    end
    s0_arvalid = 0; s1_arvalid = 0; m_rvalid = 0; m_rlast = 0; #1;
    chk("t2_cnt0", ar_cnt0, 4);
    chk("t2_cnt1", ar_cnt1, 4);

    // Outstanding limit of 2 for requester 0
    rstn = 0; tick(); rstn = 1;
    s0_arvalid = 1; n = 0;
    for (int i = 0; i < 8; i++) begin
      #1; n += s0_arready; tick();
    end
    chk("t3_s0_limit", n, 2);
    s1_arvalid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_s1_only", s1_arready, 1);
      chk("t3_s0_blocked", s0_arready, 0);
      tick();
      m_rvalid = 1; m_rid = 1; m_rlast = 1;
      tick();
      m_rvalid = 0; m_rlast = 0;
    end
    s1_arvalid = 0; m_rvalid = 1; m_rid = 0; m_rlast = 1; #1;
    chk("t3_s0_still_blocked", s0_arready, 0);
    tick(); m_rvalid = 0; m_rlast = 0; #1;
    chk("t3_s0_regrant", s0_arready, 1);
    tick(); s0_arvalid = 0; tick();

    // AR stall in HOLD, en dropped mid-HOLD
    rstn = 0; tick(); rstn = 1;
    m_arready = 0; s0_araddr = 32'h2000; s0_arlen = 8'd3; s0_arvalid = 1; #1;
    chk("t4_grant", s0_arready, 1);
    tick(); s0_arvalid = 0; s1_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) en = 0;
      #1;
      chk("t4_no_arready", s1_arready, 0);
      chk("t4_hold_valid", m_arvalid, 1);
      chk("t4_hold_addr", m_araddr, 32'h2000);
      tick();
    end
    m_arready = 1; #1; tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_en_low_nogrant", s1_arready, 0);
      chk("t4_en_low_idle", m_arvalid, 0);
      tick();
    end
    s1_arvalid = 0; en = 1;

    // Interleaved R with backpressure on requester 1
    s0_rready = 1; s1_rready = 0; m_rvalid = 1; m_rid = 1; m_rlast = 0; #1;
    chk("t5_m_rready_low", m_rready, 0);
    chk("t5_s0_rvalid_low", s0_rvalid, 0);
    chk("t5_s1_rvalid", s1_rvalid, 1);
    tick(); m_rid = 0; m_rlast = 1; #1;
    chk("t5_s0_rvalid", s0_rvalid, 1);
    chk("t5_m_rready", m_rready, 1);
    tick(); m_rvalid = 0; m_rlast = 0; #1;
    chk("t5_busy_low", busy, 0);

    // Spurious rlast sets sticky err; reset in HOLD clears everything
    m_rvalid = 1; m_rid = 1; m_rlast = 1; s1_rready = 1; #1;
    chk("t6_err_before", err, 0);
    tick(); m_rvalid = 0; m_rlast = 0; #1;
    chk("t6_err_set", err, 1);
    tick(); #1;
    chk("t6_err_sticky", err, 1);
    s0_arvalid = 1; m_arready = 0;
    tick(); s0_arvalid = 0; #1;
    chk("t6_in_hold", m_arvalid, 1);
    rstn = 0;
    tick(); #1;
    chk("t6_rst_arvalid", m_arvalid, 0);
    chk("t6_rst_cnt0", ar_cnt0, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_busy", busy, 0);
    rstn = 1;
    tick(); tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
